// File: rtl/z80_bus_master.sv
// Borrows the Z80 external bus via /BUSRQ-/BUSAK and runs one byte-wide
// memory or I/O cycle with Z80-style strobes, then hands the bus back.
module z80_bus_master #(
    parameter int WAIT_STATES   = 0,
    parameter int BUSAK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        io,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic        wait_n,
    output logic        bus_oe,
    output logic [15:0] a_o,
    output logic [7:0]  d_o,
    output logic        d_oe,
    input  logic [7:0]  d_i,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        T1,
        T2,
        T3,
        ERR,
        REL
    } state_t;

    localparam logic [15:0] TO_LIM  = 16'(BUSAK_TIMEOUT);
    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

    state_t      state;
    logic        we_q;
    logic        io_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [15:0] to_cnt;
    logic [3:0]  ws_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            to_cnt  <= 16'h0000;
            ws_cnt  <= 4'h0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 8'h00;
            busrq_n <= 1'b1;
            bus_oe  <= 1'b0;
            a_o     <= 16'h0000;
            d_o     <= 8'h00;
            d_oe    <= 1'b0;
            mreq_n  <= 1'b1;
            iorq_n  <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    busrq_n <= 1'b1;
                    bus_oe  <= 1'b0;
                    d_oe    <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        io_q    <= io;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        to_cnt  <= 16'h0000;
                        busrq_n <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        bus_oe <= 1'b1;
                        a_o    <= addr_q;
                        d_o    <= wdata_q;
                        d_oe   <= we_q;
                        state  <= T1;
                    end else if (to_cnt == TO_LIM) begin
                        ack     <= 1'b1;
                        err     <= 1'b1;
                        busrq_n <= 1'b1;
                        state   <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                T1, T2: begin
                    if (busak_n) begin
                        // Grant lost: get off the bus before anything else
                        bus_oe  <= 1'b0;
                        d_oe    <= 1'b0;
                        mreq_n  <= 1'b1;
                        iorq_n  <= 1'b1;
                        rd_n    <= 1'b1;
                        wr_n    <= 1'b1;
                        busrq_n <= 1'b1;
                        ack     <= 1'b1;
                        err     <= 1'b1;
                        state   <= ERR;
                    end else if (state == T1) begin
                        mreq_n <= io_q;
                        iorq_n <= !io_q;
                        rd_n   <= we_q;
                        wr_n   <= !we_q;
                        ws_cnt <= WS_INIT;
                        state  <= T2;
                    end else if (ws_cnt != 4'h0) begin
                        ws_cnt <= ws_cnt - 4'd1;
                    end else if (wait_n) begin
                        mreq_n <= 1'b1;
                        iorq_n <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        ack    <= 1'b1;
                        if (!we_q) begin
                            rdata <= d_i;
                        end
                        state <= T3;
                    end
                end
                T3: begin
                    bus_oe  <= 1'b0;
                    d_oe    <= 1'b0;
                    busrq_n <= 1'b1;
                    state   <= REL;
                end
                ERR: begin
                    state <= IDLE;
                end
                REL: begin
                    if (busak_n) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
